param_load_ctl: RTL and testbench

PARAM_LOAD_CTL -- requirements
Module: param_load_ctl

---
 rtl/param_load_ctl.sv | 142 ++++++++++++++
 tb/tb_param_load_ctl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/param_load_ctl.sv
// Streams filter weights or biases into F_NUM cores, stepping core index and address per accepted beat.
// Optional `PARAM_LOAD_LAST_CHECK_EN enables src_last framing check driving the sticky err flag.
module param_load_ctl #(
   parameter int F_NUM = 16,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wwrite,
   input  logic          bwrite,
   input  logic [3:0]    od,
   input  logic [AW-1:0] ks,
   input  logic          src_valid,
   input  logic          src_last,
   output logic          src_ready,
   output logic          prm_we,
   output logic [3:0]    prm_v,
   output logic [AW-1:0] prm_a,
   output logic          bias_sel,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, WLOAD, BLOAD, DONE} state_t;

   localparam logic [3:0] F_MAX = 4'(F_NUM - 1);

   state_t     state;
   logic       beat;
   logic [3:0] f_end;
   logic       f_last;
   logic       a_last;
   logic       final_beat;
   logic       last_bad;
   logic       to_done;

   // An out-of-range od is clamped so the core index never passes the last core.
   assign f_end      = (od > F_MAX) ? F_MAX : od;
   assign beat       = src_valid & src_ready;
   assign prm_we     = beat;
   assign f_last     = (prm_v == f_end);
   assign a_last     = (prm_a == ks);
   assign final_beat = beat & f_last & ((state == BLOAD) | a_last);
   assign to_done    = final_beat | last_bad;

`ifdef PARAM_LOAD_LAST_CHECK_EN
   logic err_q;

   assign last_bad = beat & (src_last != final_beat);
   assign err      = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if ((state == IDLE) && (wwrite || bwrite))
         err_q <= 1'b0;
      else if (last_bad)
         err_q <= 1'b1;
   end
`else
   logic unused_last;

   assign unused_last = src_last;
   assign last_bad    = 1'b0;
   assign err         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         prm_v     <= '0;
         prm_a     <= '0;
         src_ready <= 1'b0;
         bias_sel  <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (wwrite) begin
                  state     <= WLOAD;
                  prm_v     <= '0;
                  prm_a     <= '0;
                  src_ready <= 1'b1;
                  bias_sel  <= 1'b0;
               end else if (bwrite) begin
                  state     <= BLOAD;
                  prm_v     <= '0;
                  prm_a     <= '0;
                  src_ready <= 1'b1;
                  bias_sel  <= 1'b1;
               end
            end
            WLOAD: begin
               if (to_done) begin
                  state     <= DONE;
                  src_ready <= 1'b0;
                  done      <= 1'b1;
               end else if (!wwrite) begin
                  // Abort: any beat this cycle has already been strobed out.
                  state     <= IDLE;
                  src_ready <= 1'b0;
               end else if (beat) begin
                  if (a_last) begin
                     prm_a <= '0;
                     prm_v <= prm_v + 4'd1;
                  end else begin
                     prm_a <= prm_a + 1'b1;
                  end
               end
            end
            BLOAD: begin
               if (to_done) begin
                  state     <= DONE;
                  src_ready <= 1'b0;
                  bias_sel  <= 1'b0;
                  done      <= 1'b1;
               end else if (!bwrite) begin
                  state     <= IDLE;
                  src_ready <= 1'b0;
                  bias_sel  <= 1'b0;
               end else if (beat) begin
                  prm_a <= '0;
                  prm_v <= prm_v + 4'd1;
               end
            end
            DONE: begin
               if (!wwrite && !bwrite) begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               src_ready <= 1'b0;
               bias_sel  <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_load_ctl.sv
// Randomized bench for param_load_ctl; the expected core/address of beat k is derived arithmetically.
// Build with PARAM_LOAD_LAST_CHECK_EN to also exercise the src_last framing check.
module tb_param_load_ctl;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wwrite;
   logic          bwrite;
   logic [3:0]    od;
   logic [AW-1:0] ks;
   logic          src_valid;
   logic          src_last;
   logic          src_ready;
   logic          prm_we;
   logic [3:0]    prm_v;
   logic [AW-1:0] prm_a;
   logic          bias_sel;
   logic          done;
   logic          err;

   int n_cmp = 0;
   int n_bad = 0;

   param_load_ctl #(.F_NUM(16), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .wwrite(wwrite), .bwrite(bwrite), .od(od), .ks(ks),
      .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready), .prm_we(prm_we),
      .prm_v(prm_v), .prm_a(prm_a), .bias_sel(bias_sel), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, 32'(src_ready), 0);
      chk({tag, "_we"},    32'(prm_we), 0);
      chk({tag, "_v"},     32'(prm_v), 0);
      chk({tag, "_a"},     32'(prm_a), 0);
      chk({tag, "_bias"},  32'(bias_sel), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_err"},   32'(err), 0);
   endtask

   // Beat k of a weight load lands on core k/(ks+1), address k%(ks+1); bias beat k on core k, address 0.
   function automatic int exp_v(input bit is_bias, input int k, input int ks_i);
      return is_bias ? k : k / (ks_i + 1);
   endfunction

   function automatic int exp_a(input bit is_bias, input int k, input int ks_i);
      return is_bias ? 0 : k % (ks_i + 1);
   endfunction

   // vmode: 0 valid always, 1 valid toggling, 2 random. stop_at >= 0 interrupts after that many beats
   // by dropping the request (abort) or by pulsing reset (use_rst).
   task automatic run_load(input bit is_bias, input int od_i, input int ks_i, input int vmode,
                           input int stop_at, input bit use_rst);
      int  n, k, cyc;
      bit  mrdy, acc, tog;
      n      = is_bias ? od_i + 1 : (od_i + 1) * (ks_i + 1);
      od     = od_i[3:0];
      ks     = ks_i[AW-1:0];
      wwrite = !is_bias;
      bwrite = is_bias;
      k = 0; mrdy = 0; cyc = 0; tog = 0;
      while (k < n && cyc < 4000) begin
         if (k == stop_at && mrdy) begin
            if (use_rst) begin
               src_valid = 1'b1;
               #1 rst_n = 1'b0;
               #1 chk_zero("rst_async");
               wwrite = 1'b0; bwrite = 1'b0; src_valid = 1'b0;
               @(negedge clk);
               rst_n = 1'b1;
               @(posedge clk); #1;
               chk("rst_idle_ready", 32'(src_ready), 0);
               return;
            end else begin
               wwrite = 1'b0; bwrite = 1'b0; src_valid = 1'b1; src_last = 1'b0;
               @(negedge clk);
               chk("abort_we", 32'(prm_we), 1);
               chk("abort_v", 32'(prm_v), 32'(exp_v(is_bias, k, ks_i)));
               chk("abort_a", 32'(prm_a), 32'(exp_a(is_bias, k, ks_i)));
               @(posedge clk); #1;
               chk("abort_ready", 32'(src_ready), 0);
               chk("abort_done", 32'(done), 0);
               repeat (3) begin
                  @(negedge clk);
                  chk("abort_idle_we", 32'(prm_we), 0);
               end
               src_valid = 1'b0;
               @(posedge clk); #1;
               return;
            end
         end
         case (vmode)
            0:       src_valid = 1'b1;
            1:       begin src_valid = tog; tog = !tog; end
            default: src_valid = 1'($urandom_range(0, 1));
         endcase
`ifdef PARAM_LOAD_LAST_CHECK_EN
         src_last = (k == n - 1);
`else
         src_last = 1'($urandom_range(0, 1));
`endif
         @(negedge clk);
         acc = src_valid && mrdy;
         chk("ready", 32'(src_ready), 32'(mrdy));
         chk("we", 32'(prm_we), 32'(acc));
         if (acc) begin
            chk("v", 32'(prm_v), 32'(exp_v(is_bias, k, ks_i)));
            chk("a", 32'(prm_a), 32'(exp_a(is_bias, k, ks_i)));
            chk("bias_sel", 32'(bias_sel), 32'(is_bias));
            chk("done_early", 32'(done), 0);
            k++;
         end
         @(posedge clk); #1;
         mrdy = (k < n);
         cyc++;
      end
      chk("beats", 32'(k), 32'(n));
      chk("done", 32'(done), 1);
      chk("done_ready", 32'(src_ready), 0);
      chk("done_err", 32'(err), 0);
      chk("done_bias", 32'(bias_sel), 0);
      src_valid = 1'b1;
      @(negedge clk);
      chk("done_we", 32'(prm_we), 0);
      wwrite = 1'b0; bwrite = 1'b0; src_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle_done", 32'(done), 0);
   endtask

   initial begin
      rst_n = 1'b0; wwrite = 1'b0; bwrite = 1'b0; od = '0; ks = '0;
      src_valid = 1'b0; src_last = 1'b0;
      #2 chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_ready", 32'(src_ready), 0);

      run_load(1'b0, 2, 3, 0, -1, 1'b0);    // 12 continuous weight beats
      run_load(1'b1, 15, 5, 1, -1, 1'b0);   // 16 bias beats, valid toggling
      run_load(1'b0, 3, 7, 2, 10, 1'b1);    // reset after 10 beats
      run_load(1'b0, 3, 7, 0, -1, 1'b0);    // restart from 0/0
      run_load(1'b0, 1, 4, 2, 3, 1'b0);     // abort after 3 beats
      run_load(1'b1, 0, 0, 0, -1, 1'b0);    // single bias beat
      run_load(1'b0, 0, 0, 2, -1, 1'b0);    // single weight beat

`ifdef PARAM_LOAD_LAST_CHECK_EN
      begin
         int nwe;
         nwe = 0;
         od = 4'd1; ks = AW'(1); wwrite = 1'b1; src_valid = 1'b1;
         for (int c = 0; c < 8; c++) begin
            src_last = (nwe == 1);
            @(negedge clk);
            if (prm_we) begin
               chk("lc_v", 32'(prm_v), 32'(exp_v(1'b0, nwe, 1)));
               chk("lc_a", 32'(prm_a), 32'(exp_a(1'b0, nwe, 1)));
               nwe++;
            end
            @(posedge clk); #1;
         end
         chk("lc_we_count", 32'(nwe), 2);
         chk("lc_err", 32'(err), 1);
         chk("lc_done", 32'(done), 1);
         wwrite = 1'b0; src_valid = 1'b0; src_last = 1'b0;
         @(posedge clk); #1;
         chk("lc_err_sticky", 32'(err), 1);
      end
      run_load(1'b0, 1, 1, 0, -1, 1'b0);    // new load clears err
`endif

      for (int i = 0; i < 6; i++) begin
         run_load(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 5)), 2, -1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
